// File: rtl/ad9361_spi_pkg.sv
// Shared constants, FSM encoding and status-forcing helper for the AD9361
// SPI responder model.
package ad9361_spi_pkg;

    // Frame layout, bit 23 shifted first.
    localparam int FRAME_BITS   = 24;
    localparam int W_BIT        = 23;
    localparam int ADDR_MSB     = 17;
    localparam int ADDR_LSB     = 8;
    localparam int DATA_MSB     = 7;
    localparam int DATA_LSB     = 0;

    // Derived positions inside the 16-bit command word (the first 16 bits).
    localparam int DATA_BITS    = DATA_MSB - DATA_LSB + 1;
    localparam int CMD_BITS     = FRAME_BITS - DATA_BITS;
    localparam int CMD_W_POS    = W_BIT - DATA_BITS;
    localparam int ADDR_FIELD_W = ADDR_MSB - ADDR_LSB + 1;

    localparam logic [4:0] CNT_CMD  = 5'(CMD_BITS);
    localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_RDLAT = 3'd2,
        ST_DATA  = 3'd3,
        ST_DONE  = 3'd4
    } spi_state_e;

    // Status registers the init sequencer polls.
    localparam logic [9:0] STAT_ADDR_05E = 10'h05E;
    localparam logic [9:0] STAT_ADDR_244 = 10'h244;
    localparam logic [9:0] STAT_ADDR_284 = 10'h284;
    localparam logic [9:0] STAT_ADDR_247 = 10'h247;
    localparam logic [9:0] STAT_ADDR_287 = 10'h287;
    localparam logic [9:0] STAT_ADDR_016 = 10'h016;

    localparam logic [7:0] STAT_OR_B7   = 8'h80;
    localparam logic [7:0] STAT_OR_B1   = 8'h02;
    // Calibration-busy bits 7,6,4,0 always read back clear.
    localparam logic [7:0] STAT_AND_CAL = 8'h2E;

    // Apply lock/calibration forcing to a raw register byte.
    function automatic logic [7:0] force_status(
        input logic [ADDR_FIELD_W-1:0] addr,
        input logic [7:0]              data,
        input logic                    en
    );
        logic [7:0] res;
        res = data;
        if (en) begin
            case (addr)
                STAT_ADDR_05E, STAT_ADDR_244, STAT_ADDR_284: res = data | STAT_OR_B7;
                STAT_ADDR_247, STAT_ADDR_287:                res = data | STAT_OR_B1;
                STAT_ADDR_016:                               res = data & STAT_AND_CAL;
                default:                                     res = data;
            endcase
        end else begin
            res = data;
        end
        return res;
    endfunction

endpackage

// File: rtl/ad9361_spi_sync.sv
// Two-flop synchroniser with registered rise/fall strobes.
// Pin edge to strobe is 3 clk; dout is the synchronised level (2 clk).
module ad9361_spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic meta_r;
    logic sync_r;
    logic dly_r;
    logic rise_r;
    logic fall_r;

    // Resynchronise the pin and register single-cycle edge strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= RST_VAL;
            sync_r <= RST_VAL;
            dly_r  <= RST_VAL;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            dly_r  <= sync_r;
            rise_r <= sync_r & ~dly_r;
            fall_r <= ~sync_r & dly_r;
        end
    end

    assign dout = sync_r;
    assign rise = rise_r;
    assign fall = fall_r;

endmodule

// File: rtl/ad9361_spi_slave.sv
// Behavioural AD9361 SPI responder: oversamples the SPI pins, decodes 24-bit
// frames into a byte-wide register file and returns (status-forced) read data.
module ad9361_spi_slave
    import ad9361_spi_pkg::*;
#(
    parameter int ADDR_W       = 10,
    parameter bit FORCE_STATUS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spi_csn,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    output logic              spi_miso,
    output logic              wr_stb,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              rd_stb,
    output logic              frame_err,
    output logic              busy
);

    logic sclk_lvl_unused_s;
    logic sclk_rise_s;
    logic sclk_fall_s;
    logic csn_lvl_s;
    logic csn_rise_s;
    logic csn_fall_s;
    logic mosi_s;
    logic mosi_rise_unused_s;
    logic mosi_fall_unused_s;

    ad9361_spi_sync #(.RST_VAL(1'b0)) u_sync_sclk (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (spi_clk),
        .dout (sclk_lvl_unused_s),
        .rise (sclk_rise_s),
        .fall (sclk_fall_s)
    );

    ad9361_spi_sync #(.RST_VAL(1'b1)) u_sync_csn (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (spi_csn),
        .dout (csn_lvl_s),
        .rise (csn_rise_s),
        .fall (csn_fall_s)
    );

    ad9361_spi_sync #(.RST_VAL(1'b0)) u_sync_mosi (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (spi_mosi),
        .dout (mosi_s),
        .rise (mosi_rise_unused_s),
        .fall (mosi_fall_unused_s)
    );

    spi_state_e          state_r,   state_n;
    logic [4:0]          bit_cnt_r, bit_cnt_n;
    logic [CMD_BITS-2:0] shift_r,   shift_n;
    logic                is_wr_r,   is_wr_n;
    logic [ADDR_W-1:0]   addr_r,    addr_n;
    logic                rd_wait_r, rd_wait_n;
    logic [7:0]          miso_sr_r, miso_sr_n;
    logic                miso_r,    miso_n;
    logic                wr_stb_r,  wr_stb_n;
    logic [ADDR_W-1:0]   wr_addr_r, wr_addr_n;
    logic [7:0]          wr_data_r, wr_data_n;
    logic                rd_stb_r,  rd_stb_n;
    logic                ferr_r,    ferr_n;
    logic                busy_r;
    logic                ram_we_s;

    logic [CMD_BITS-1:0]          shift_in_s;
    logic [4:0]                   cnt_inc_s;
    logic [7:0]                   rd_byte_s;
    logic [CMD_W_POS-1:ADDR_W]    cmd_field_unused_s;

    logic [7:0] mem_r [0:(1<<ADDR_W)-1];
    logic [7:0] ram_q_r;

    // Shift register view including the bit arriving on this SCLK rise.
    assign shift_in_s         = {shift_r, mosi_s};
    assign cnt_inc_s          = (bit_cnt_r == CNT_FULL) ? CNT_FULL : (bit_cnt_r + 5'd1);
    assign rd_byte_s          = force_status(10'(addr_r), ram_q_r, FORCE_STATUS);
    assign cmd_field_unused_s = shift_in_s[CMD_W_POS-1:ADDR_W];

    // Frame decoder: next state and next values of all registered outputs.
    always_comb begin
        state_n   = state_r;
        bit_cnt_n = bit_cnt_r;
        shift_n   = shift_r;
        is_wr_n   = is_wr_r;
        addr_n    = addr_r;
        rd_wait_n = rd_wait_r;
        miso_sr_n = miso_sr_r;
        miso_n    = miso_r;
        wr_stb_n  = 1'b0;
        wr_addr_n = wr_addr_r;
        wr_data_n = wr_data_r;
        rd_stb_n  = 1'b0;
        ferr_n    = 1'b0;
        ram_we_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                miso_n = 1'b0;
                if (csn_fall_s) begin
                    state_n   = ST_CMD;
                    bit_cnt_n = 5'd0;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (csn_rise_s) begin
                    state_n = ST_IDLE;
                    ferr_n  = (bit_cnt_r < CNT_FULL);
                    miso_n  = 1'b0;
                end else if (sclk_rise_s) begin
                    shift_n   = shift_in_s[CMD_BITS-2:0];
                    bit_cnt_n = cnt_inc_s;
                    if (cnt_inc_s == CNT_CMD) begin
                        is_wr_n   = shift_in_s[CMD_W_POS];
                        addr_n    = shift_in_s[ADDR_W-1:0];
                        rd_wait_n = 1'b1;
                        if (shift_in_s[CMD_W_POS]) begin
                            state_n = ST_DATA;
                        end else begin
                            state_n = ST_RDLAT;
                        end
                    end else begin
                        state_n = ST_CMD;
                    end
                end else begin
                    state_n = ST_CMD;
                end
            end
            ST_RDLAT: begin
                if (csn_rise_s) begin
                    state_n = ST_IDLE;
                    ferr_n  = (bit_cnt_r < CNT_FULL);
                    miso_n  = 1'b0;
                end else if (rd_wait_r) begin
                    // RAM output becomes valid one cycle after the address.
                    rd_wait_n = 1'b0;
                end else begin
                    // Bit 7 goes out now and again on the next SCLK fall.
                    miso_sr_n = rd_byte_s;
                    miso_n    = rd_byte_s[7];
                    rd_stb_n  = 1'b1;
                    state_n   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (csn_rise_s) begin
                    state_n = ST_IDLE;
                    ferr_n  = (bit_cnt_r < CNT_FULL);
                    miso_n  = 1'b0;
                end else if (sclk_rise_s) begin
                    shift_n   = shift_in_s[CMD_BITS-2:0];
                    bit_cnt_n = cnt_inc_s;
                    if (cnt_inc_s == CNT_FULL) begin
                        state_n = ST_DONE;
                        miso_n  = 1'b0;
                        if (is_wr_r) begin
                            ram_we_s  = 1'b1;
                            wr_stb_n  = 1'b1;
                            wr_addr_n = addr_r;
                            wr_data_n = shift_in_s[7:0];
                        end else begin
                            wr_stb_n = 1'b0;
                        end
                    end else begin
                        state_n = ST_DATA;
                    end
                end else if (sclk_fall_s && !is_wr_r) begin
                    miso_n    = miso_sr_r[7];
                    miso_sr_n = {miso_sr_r[6:0], 1'b0};
                end else begin
                    state_n = ST_DATA;
                end
            end
            ST_DONE: begin
                miso_n = 1'b0;
                if (csn_fall_s) begin
                    state_n   = ST_CMD;
                    bit_cnt_n = 5'd0;
                end else if (csn_rise_s) begin
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_DONE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                miso_n  = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 5'd0;
            shift_r   <= {(CMD_BITS-1){1'b0}};
            is_wr_r   <= 1'b0;
            addr_r    <= {ADDR_W{1'b0}};
            rd_wait_r <= 1'b0;
            miso_sr_r <= 8'h00;
            miso_r    <= 1'b0;
            wr_stb_r  <= 1'b0;
            wr_addr_r <= {ADDR_W{1'b0}};
            wr_data_r <= 8'h00;
            rd_stb_r  <= 1'b0;
            ferr_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_n;
            bit_cnt_r <= bit_cnt_n;
            shift_r   <= shift_n;
            is_wr_r   <= is_wr_n;
            addr_r    <= addr_n;
            rd_wait_r <= rd_wait_n;
            miso_sr_r <= miso_sr_n;
            miso_r    <= miso_n;
            wr_stb_r  <= wr_stb_n;
            wr_addr_r <= wr_addr_n;
            wr_data_r <= wr_data_n;
            rd_stb_r  <= rd_stb_n;
            ferr_r    <= ferr_n;
            busy_r    <= ~csn_lvl_s;
        end
    end

    // Register file: deliberately not reset, content survives rst_n.
    always_ff @(posedge clk) begin
        if (ram_we_s) begin
            mem_r[addr_r] <= wr_data_n;
        end
        ram_q_r <= mem_r[addr_r];
    end

    assign spi_miso  = miso_r;
    assign wr_stb    = wr_stb_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign rd_stb    = rd_stb_r;
    assign frame_err = ferr_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_ad9361_spi_slave.sv
// Directed + randomized bench for ad9361_spi_slave with a byte-array model.
module tb_ad9361_spi_slave;

    localparam int HALF = 6;   // SCLK half period in clk cycles (12x oversampling)

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       spi_csn  = 1'b1;
    logic       spi_clk  = 1'b0;
    logic       spi_mosi = 1'b0;
    logic       spi_miso;
    logic       wr_stb;
    logic [9:0] wr_addr;
    logic [7:0] wr_data;
    logic       rd_stb;
    logic       frame_err;
    logic       busy;

    ad9361_spi_slave #(.ADDR_W(10), .FORCE_STATUS(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_csn  (spi_csn),
        .spi_clk  (spi_clk),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .wr_stb   (wr_stb),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_stb   (rd_stb),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int wr_pulses  = 0;
    int rd_pulses  = 0;
    int err_pulses = 0;

    logic [7:0] model_mem [1024];
    int         written_q [$];

    // Pulse counters sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_stb)    wr_pulses++;
        if (rd_stb)    rd_pulses++;
        if (frame_err) err_pulses++;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected read-back: stored byte with the status forcing rules applied.
    function automatic logic [7:0] ref_read(input int a);
        logic [7:0] v;
        v = model_mem[a];
        if (a == 'h05E || a == 'h244 || a == 'h284) v = v | 8'h80;
        else if (a == 'h247 || a == 'h287)          v = v | 8'h02;
        else if (a == 'h016)                        v = v & ~8'hD1;
        return v;
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic csn_low();
        spi_csn = 1'b0;
        wait_clk(8);
    endtask

    task automatic csn_high();
        wait_clk(HALF);
        spi_csn = 1'b1;
        wait_clk(10);
    endtask

    // One SCLK period: present MOSI, sample MISO just before the rising edge.
    task automatic sclk_bit(input logic b, output logic m);
        spi_mosi = b;
        wait_clk(HALF);
        m = spi_miso;
        spi_clk = 1'b1;
        wait_clk(HALF);
        spi_clk = 1'b0;
    endtask

    task automatic xfer(input logic [23:0] frame, input int nbits,
                        output logic [7:0] rd_byte, output int late_miso);
        logic m;
        rd_byte   = 8'h00;
        late_miso = 0;
        csn_low();
        for (int i = 0; i < nbits; i++) begin
            sclk_bit((i < 24) ? frame[23-i] : 1'($urandom), m);
            if (i >= 16 && i < 24) rd_byte[23-i] = m;
            if (i >= 24 && m !== 1'b0) late_miso++;
        end
        csn_high();
    endtask

    task automatic write_reg(input int a, input logic [7:0] d);
        logic [7:0] rb;
        int late;
        logic [9:0] a10;
        a10 = 10'(a);
        xfer({1'b1, 5'b00000, a10, d}, 24, rb, late);
        model_mem[a] = d;
        written_q.push_back(a);
    endtask

    task automatic read_reg(input int a, output logic [7:0] rb);
        int late;
        logic [9:0] a10;
        a10 = 10'(a);
        xfer({1'b0, 5'b00000, a10, 8'h00}, 24, rb, late);
    endtask

    initial begin
        logic [7:0] rb;
        int late, w0, r0, e0, a, idx;
        logic [7:0] d;
        logic [23:0] rd_frame;
        logic m;

        // Reset state
        wait_clk(4);
        chk("rst_miso", spi_miso, 0);
        chk("rst_wr_stb", wr_stb, 0);
        chk("rst_rd_stb", rd_stb, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        rst_n = 1'b1;
        wait_clk(5);

        // Basic write then read back
        w0 = wr_pulses;
        xfer(24'h80A53C, 24, rb, late);
        model_mem['h0A5] = 8'h3C;
        written_q.push_back('h0A5);
        chk("wr_stb_count", wr_pulses - w0, 1);
        chk("wr_addr", wr_addr, 'h0A5);
        chk("wr_data", wr_data, 'h3C);
        r0 = rd_pulses;
        xfer(24'h00A500, 24, rb, late);
        chk("rd_0A5", rb, 'h3C);
        chk("rd_stb_count", rd_pulses - r0, 1);

        // busy follows CSN; an empty CSN window is an aborted frame
        e0 = err_pulses;
        spi_csn = 1'b0;
        wait_clk(8);
        chk("busy_high", busy, 1);
        spi_csn = 1'b1;
        wait_clk(8);
        chk("busy_low", busy, 0);
        chk("empty_frame_err", err_pulses - e0, 1);

        // Forced status reads
        write_reg('h05E, 8'h00);
        read_reg('h05E, rb);
        chk("force_05E", rb, 'h80);
        write_reg('h247, 8'h00);
        read_reg('h247, rb);
        chk("force_247", rb, 'h02);
        write_reg('h016, 8'hFF);
        read_reg('h016, rb);
        chk("force_016", rb, ref_read('h016));

        // Aborted write after 12 bits leaves RAM untouched
        write_reg('h012, 8'h77);
        w0 = wr_pulses;
        e0 = err_pulses;
        xfer(24'h801255, 12, rb, late);
        chk("abort_frame_err", err_pulses - e0, 1);
        chk("abort_no_wr", wr_pulses - w0, 0);
        read_reg('h012, rb);
        chk("abort_rd_012", rb, 'h77);

        // 32 SCLK cycles in one window: one write, MISO quiet after bit 24
        w0 = wr_pulses;
        xfer(24'h8033C5, 32, rb, late);
        model_mem['h033] = 8'hC5;
        written_q.push_back('h033);
        chk("long_wr_count", wr_pulses - w0, 1);
        chk("long_wr_miso", late, 0);
        chk("long_wr_data", wr_data, 'hC5);
        xfer(24'h003300, 32, rb, late);
        chk("long_rd_data", rb, 'hC5);
        chk("long_rd_miso", late, 0);

        // Reset during bit 20 of a read
        rd_frame = 24'h003300;
        csn_low();
        for (int i = 0; i < 20; i++) sclk_bit(rd_frame[23-i], m);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_miso", spi_miso, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wr_addr", wr_addr, 0);
        chk("mid_rst_wr_data", wr_data, 0);
        chk("mid_rst_pulses", {wr_stb, rd_stb, frame_err}, 0);
        spi_csn = 1'b1;
        wait_clk(10);
        rst_n = 1'b1;
        wait_clk(5);
        write_reg('h1F0, 8'hA7);
        chk("post_rst_wr_addr", wr_addr, 'h1F0);
        read_reg('h1F0, rb);
        chk("post_rst_rd", rb, 'hA7);

        // Randomized writes and read-backs against the model
        for (int k = 0; k < 16; k++) begin
            a = int'($urandom_range(0, 1023));
            d = 8'($urandom);
            write_reg(a, d);
            chk("rnd_wr_addr", wr_addr, a);
            chk("rnd_wr_data", wr_data, d);
            idx = int'($urandom_range(0, written_q.size() - 1));
            a = written_q[idx];
            read_reg(a, rb);
            chk("rnd_rd", rb, ref_read(a));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
